// File: rtl/sqrt_pwl_pkg.sv
// Shared widths and coefficient record for the piecewise-linear sqrt stage.
package sqrt_pwl_pkg;

   localparam int unsigned DEF_X_W      = 32;
   localparam int unsigned DEF_SEG_BITS = 6;
   localparam int unsigned DEF_XB_W     = 12;
   localparam int unsigned DEF_C1_W     = 12;
   localparam int unsigned DEF_C0_W     = 20;
   localparam int unsigned DEF_C1_SHIFT = 12;
   localparam int unsigned COEF_W       = DEF_C1_W + DEF_C0_W;

   typedef struct packed {
      logic [DEF_C1_W-1:0] c1;
      logic [DEF_C0_W-1:0] c0;
   } coef_t;

   function automatic coef_t make_coef(input logic [DEF_C1_W-1:0] c1,
                                       input logic [DEF_C0_W-1:0] c0);
      coef_t c;
      c.c1 = c1;
      c.c0 = c0;
      return c;
   endfunction

endpackage

// File: rtl/sqrt_pwl_coef_ram.sv
// Coefficient store: one synchronous write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module sqrt_pwl_coef_ram
   import sqrt_pwl_pkg::*;
#(
   parameter int unsigned AW = DEF_SEG_BITS + 1,
   parameter int unsigned DW = COEF_W
)(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sqrt_pwl_pipe.sv
// Three-stage piecewise-linear sqrt: y = c0 + (c1*xb >> C1_SHIFT), with
// run-time loadable coefficient banks for [1,2) and [2,4), valid/ready both sides.
module sqrt_pwl_pipe
   import sqrt_pwl_pkg::*;
#(
   parameter int unsigned X_W      = DEF_X_W,
   parameter int unsigned SEG_BITS = DEF_SEG_BITS,
   parameter int unsigned XB_W     = DEF_XB_W,
   parameter int unsigned C1_W     = DEF_C1_W,
   parameter int unsigned C0_W     = DEF_C0_W,
   parameter int unsigned C1_SHIFT = DEF_C1_SHIFT
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cfg_we,
   input  logic [SEG_BITS:0]      cfg_addr,
   input  logic [C1_W+C0_W-1:0]   cfg_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [X_W-1:0]         x_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [C0_W-1:0]        y_out,
   output logic                   out_err,
   output logic                   out_sat
);

   localparam int unsigned AW = SEG_BITS + 1;
   localparam int unsigned CW = C1_W + C0_W;
   localparam int unsigned PW = C1_W + XB_W;

   logic              adv;
   logic              bank;
   logic [SEG_BITS-1:0] seg;
   logic [AW-1:0]     raddr;
   logic [XB_W-1:0]   xb0;
   logic              err0;

   logic              v1, v2;
   logic [CW-1:0]     coef1;
   logic [XB_W-1:0]   xb1;
   logic              err1;
   logic [PW-1:0]     p2;
   logic [C0_W-1:0]   c0_2;
   logic              err2;
   logic [PW-1:0]     psh;
   logic [C0_W:0]     s;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Bank 1 spans twice the range of bank 0, so its fields sit one bit higher.
   always_comb begin
      bank = x_in[X_W-1];
      err0 = (x_in[X_W-1 -: 2] == 2'b00);
      if (bank) begin
         seg = x_in[X_W-2 -: SEG_BITS];
         xb0 = x_in[X_W-2-SEG_BITS -: XB_W];
      end else begin
         seg = x_in[X_W-3 -: SEG_BITS];
         xb0 = x_in[X_W-3-SEG_BITS -: XB_W];
      end
      raddr = {bank, seg};
   end

   sqrt_pwl_coef_ram #(
      .AW (AW),
      .DW (CW)
   ) u_ram (
      .clk   (clk),
      .we    (cfg_we),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .re    (adv),
      .raddr (raddr),
      .rdata (coef1)
   );

   always_ff @(posedge clk) begin
      if (adv) begin
         xb1  <= xb0;
         err1 <= err0;
         p2   <= PW'(coef1[CW-1 -: C1_W]) * PW'(xb1);
         c0_2 <= coef1[C0_W-1:0];
         err2 <= err1;
      end
   end

   always_comb begin
      psh = p2 >> C1_SHIFT;
      s   = (C0_W+1)'(c0_2) + (C0_W+1)'(psh);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         y_out     <= '0;
         out_err   <= 1'b0;
         out_sat   <= 1'b0;
      end else if (adv) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         if (v2) begin
            if (err2) begin
               y_out   <= '0;
               out_err <= 1'b1;
               out_sat <= 1'b0;
            end else if (s[C0_W]) begin
               y_out   <= '1;
               out_err <= 1'b0;
               out_sat <= 1'b1;
            end else begin
               y_out   <= s[C0_W-1:0];
               out_err <= 1'b0;
               out_sat <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sqrt_pwl_pipe.sv
// Scoreboard bench for sqrt_pwl_pipe: directed cases plus a randomized stream
// checked against an arithmetic model of the segment/slope evaluation.
module tb_sqrt_pwl_pipe;
   import sqrt_pwl_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cfg_we;
   logic [6:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x_in;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] y_out;
   logic        out_err;
   logic        out_sat;

   sqrt_pwl_pipe #(
      .X_W      (32),
      .SEG_BITS (6),
      .XB_W     (12),
      .C1_W     (12),
      .C0_W     (20),
      .C1_SHIFT (12)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y_out     (y_out),
      .out_err   (out_err),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] y;
      logic        e;
      logic        s;
      bit          lat;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [128];
   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   int unsigned cyc = 0;
   int          orm = 0;   // out_ready mode: 0 always 1, 1 random, 2 always 0

   always @(posedge clk) cyc++;

   function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
      end
   endfunction

   function automatic void model(input logic [31:0] x, output logic [19:0] y,
                                 output logic e, output logic s);
      longint unsigned off, xb, c1, c0, sum;
      int unsigned idx;
      logic [31:0] w;
      y = '0; e = 1'b0; s = 1'b0;
      if (x < 32'h4000_0000) begin
         e = 1'b1;
         return;
      end
      if (x >= 32'h8000_0000) begin
         off = {32'b0, x} - 64'h8000_0000;
         idx = 64 + 32'(off / (64'd1 << 25));
         xb  = (off / (64'd1 << 13)) % 4096;
      end else begin
         off = {32'b0, x} - 64'h4000_0000;
         idx = 32'(off / (64'd1 << 24));
         xb  = (off / (64'd1 << 12)) % 4096;
      end
      w   = mdl[idx];
      c1  = {52'b0, w[31:20]};
      c0  = {44'b0, w[19:0]};
      sum = c0 + (c1 * xb) / 4096;
      if (sum > 64'hF_FFFF) begin
         y = 20'hF_FFFF;
         s = 1'b1;
      end else begin
         y = 20'(sum);
      end
   endfunction

   function automatic logic pick_or();
      if (orm == 0) return 1'b1;
      if (orm == 2) return 1'b0;
      return 1'($urandom_range(0, 1));
   endfunction

   // Called #1 after the negedge drive: checks in_ready and mirrors cfg writes.
   task automatic post_drive();
      chk("in_ready_eq_adv", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (cfg_we) mdl[cfg_addr] = cfg_data;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid  = 1'b0;
         cfg_we    = 1'b0;
         out_ready = pick_or();
         #1;
         post_drive();
      end
   endtask

   task automatic cfg_load(input logic [6:0] a, input logic [11:0] c1, input logic [19:0] c0);
      @(negedge clk);
      in_valid  = 1'b0;
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_data  = make_coef(c1, c0);
      out_ready = pick_or();
      #1;
      post_drive();
   endtask

   task automatic send(input logic [31:0] x, input bit lat, input bit ovr,
                       input logic [19:0] ey, input logic ee, input logic es,
                       input bit we, input logic [6:0] wa, input logic [31:0] wd);
      bit   done = 0;
      exp_t ex;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         cfg_we = (t == 0) ? we : 1'b0;
         if (t == 0 && we) begin
            cfg_addr = wa;
            cfg_data = wd;
         end
         in_valid  = 1'b1;
         x_in      = x;
         out_ready = pick_or();
         #1;
         if (in_ready) begin
            if (ovr) begin
               ex.y = ey; ex.e = ee; ex.s = es;
            end else begin
               model(x, ex.y, ex.e, ex.s);
            end
            ex.lat = lat;
            ex.cyc = cyc;
            sb.push_back(ex);
            done = 1;
         end
         post_drive();
      end
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() > 0; i++) idle(1);
      chk("drain_left", sb.size(), 32'd0);
   endtask

   // Monitor: compares each transferred output with the scoreboard head.
   initial begin
      bit          hold = 0;
      logic [19:0] hy;
      logic        he, hs;
      exp_t        ex;
      forever begin
         @(negedge clk);
         #2;
         if (reset_n !== 1'b1) begin
            hold = 0;
            continue;
         end
         if (hold) begin
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_y", {12'b0, y_out}, {12'b0, hy});
            chk("stall_flags", {30'b0, out_err, out_sat}, {30'b0, he, hs});
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", {12'b0, y_out}, 32'hDEAD_BEEF);
            end else begin
               ex = sb.pop_front();
               chk("y_out", {12'b0, y_out}, {12'b0, ex.y});
               chk("out_err", {31'b0, out_err}, {31'b0, ex.e});
               chk("out_sat", {31'b0, out_sat}, {31'b0, ex.s});
               if (ex.lat) chk("latency", cyc - ex.cyc, 32'd3);
            end
         end
         hold = out_valid && !out_ready;
         hy = y_out; he = out_err; hs = out_sat;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] x;
      reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_y_out", {12'b0, y_out}, 32'd0);
      chk("rst_out_err", {31'b0, out_err}, 32'd0);
      chk("rst_out_sat", {31'b0, out_sat}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      reset_n = 1'b1;

      // Directed cases
      cfg_load(7'd64, 12'h1FE, 20'h201FC);
      idle(1);
      send(32'h8000_0000, 1, 1, 20'h201FC, 1'b0, 1'b0, 0, '0, '0);
      idle(4);
      send(32'h8100_0000, 1, 1, 20'h202FB, 1'b0, 1'b0, 0, '0, '0);
      idle(4);
      cfg_load(7'd5, 12'h100, 20'h10000);
      send(32'h4500_0000, 1, 1, 20'h10000, 1'b0, 1'b0, 0, '0, '0);
      cfg_load(7'd127, 12'hFFF, 20'hFFFFF);
      send(32'hFFFF_FFFF, 0, 1, 20'hFFFFF, 1'b0, 1'b1, 0, '0, '0);
      send(32'h2000_0000, 0, 1, 20'h00000, 1'b1, 1'b0, 0, '0, '0);
      idle(4);
      drain();

      // Write/read collision: same-edge accept sees old c0, next accept sees new
      send(32'h8000_0000, 0, 1, 20'h201FC, 1'b0, 1'b0, 1, 7'd64, make_coef(12'h1FE, 20'h30000));
      send(32'h8000_0000, 0, 1, 20'h30000, 1'b0, 1'b0, 0, '0, '0);
      idle(1);
      drain();

      // Backpressure burst of 8
      orm = 1;
      for (int i = 0; i < 8; i++) send(32'h8000_0000 + (i << 24), 0, 0, '0, 1'b0, 1'b0, 0, '0, '0);
      drain();

      // Random stream against the model
      orm = 0;
      for (int a = 0; a < 128; a++)
         cfg_load(7'(a), 12'($urandom), 20'($urandom));
      orm = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) x = $urandom_range(0, 32'h3FFF_FFFF);
         else x = $urandom_range(32'h4000_0000, 32'hFFFF_FFFF);
         if ($urandom_range(0, 15) == 0)
            send(x, 0, 0, '0, 1'b0, 1'b0, 1, 7'($urandom), make_coef(12'($urandom), 20'($urandom)));
         else
            send(x, 0, 0, '0, 1'b0, 1'b0, 0, '0, '0);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      orm = 0;
      drain();

      // Reset with three results in flight
      orm = 2;
      for (int i = 0; i < 3; i++) send(32'h8000_0000, 0, 0, '0, 1'b0, 1'b0, 0, '0, '0);
      @(negedge clk);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      orm = 0;
      idle(8);
      send(32'h8000_0000, 1, 0, '0, 1'b0, 1'b0, 0, '0, '0);
      idle(4);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
